// File: rtl/shift_sequencer_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the shift sequencer.
package shift_sequencer_pkg;

   localparam logic [1:0] OP_SHR = 2'b00;
   localparam logic [1:0] OP_SHL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_LOAD  = 2'b01,
      S_SHIFT = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   function automatic logic op_is_left(input logic [1:0] op);
      return (op == OP_SHL) || (op == OP_ROL);
   endfunction

   function automatic logic op_is_rotate(input logic [1:0] op);
      return (op == OP_ROR) || (op == OP_ROL);
   endfunction

endpackage

// File: rtl/shift_sequencer_shift_reg_core.sv
// Universal WIDTH-bit shift register: parallel load (priority) or one-bit shift per enabled edge.
module shift_reg_core #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_input,
   input  logic             i_dir,
   input  logic             i_left_in,
   input  logic             i_right_in,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Register contents: load beats shift; Dir=1 moves toward MSB, Dir=0 toward LSB.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= {WIDTH{1'b0}};
      end else if (i_load) begin
         r_q <= i_input;
      end else if (i_enable) begin
         if (i_dir) begin
            r_q <= {r_q[WIDTH-2:0], i_right_in};
         end else begin
            r_q <= {i_left_in, r_q[WIDTH-1:1]};
         end
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer: latches one load+shift/rotate command and drives shift_reg_core step by step.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_data,
   input  logic [1:0]       i_op,
   input  logic             i_fill,
   input  logic [CNT_W-1:0] i_count,
   input  logic             i_hold,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_q
);

   state_t           r_state;
   state_t           w_next_state;
   logic [1:0]       r_op;
   logic             r_fill;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_q;
   logic             w_accept;
   logic             w_last_step;
   logic             w_load;
   logic             w_enable;
   logic             w_dir;
   logic             w_left_in;
   logic             w_right_in;

   assign w_accept    = (r_state == S_IDLE) && i_start;
   assign w_last_step = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next_state = S_LOAD;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_LOAD: begin
            if (r_count != {CNT_W{1'b0}}) begin
               w_next_state = S_SHIFT;
            end else begin
               w_next_state = S_DONE;
            end
         end
         S_SHIFT: begin
            if (!i_hold && w_last_step) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_SHIFT;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Command capture at acceptance, so host inputs may change while the command runs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op    <= 2'b00;
         r_fill  <= 1'b0;
         r_count <= {CNT_W{1'b0}};
         r_data  <= {WIDTH{1'b0}};
      end else if (w_accept) begin
         r_op    <= i_op;
         r_fill  <= i_fill;
         r_count <= i_count;
         r_data  <= i_data;
      end else begin
         r_op    <= r_op;
         r_fill  <= r_fill;
         r_count <= r_count;
         r_data  <= r_data;
      end
   end

   // Remaining-step counter: armed in LOAD, decremented on each unheld step.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (r_state == S_LOAD) begin
         r_cnt <= r_count;
      end else if ((r_state == S_SHIFT) && !i_hold) begin
         r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // FSM output decode; rotates recirculate the bit that falls off the far end.
   always_comb begin
      w_load     = 1'b0;
      w_enable   = 1'b0;
      w_dir      = op_is_left(r_op);
      w_left_in  = r_fill;
      w_right_in = r_fill;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      if (op_is_rotate(r_op)) begin
         w_left_in  = w_q[0];
         w_right_in = w_q[WIDTH-1];
      end else begin
         w_left_in  = r_fill;
         w_right_in = r_fill;
      end
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
         end
         S_LOAD: begin
            w_load = 1'b1;
            o_busy = 1'b1;
         end
         S_SHIFT: begin
            w_enable = !i_hold;
            o_busy   = 1'b1;
         end
         S_DONE: begin
            o_done = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
            o_done = 1'b0;
         end
      endcase
   end

   shift_reg_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_enable   (w_enable),
      .i_load     (w_load),
      .i_input    (r_data),
      .i_dir      (w_dir),
      .i_left_in  (w_left_in),
      .i_right_in (w_right_in),
      .o_q        (w_q)
   );

   assign o_q = w_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Table-driven scoreboard bench for shift_sequencer plus hand-written reset-abort sequence.
module tb_shift_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] data;
   logic [1:0] op;
   logic       fill;
   logic [3:0] count;
   logic       hold;
   logic       busy;
   logic       done;
   logic [3:0] q;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] data;
      logic [1:0] op;
      logic       fill;
      logic [3:0] count;
      int         hold_after;
      int         hold_len;
      int         start_at;
      logic [3:0] exp_final;
   } vec_t;

   typedef struct {
      logic       busy;
      logic       done;
      logic [3:0] q;
   } obs_t;

   obs_t sb[$];
   vec_t vecs[8];
   logic [3:0] prev_q;

   shift_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_data  (data),
      .i_op    (op),
      .i_fill  (fill),
      .i_count (count),
      .i_hold  (hold),
      .o_busy  (busy),
      .o_done  (done),
      .o_q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] model_step(input logic [3:0] v, input logic [1:0] o, input logic f);
      case (o)
         2'b00:   return {f, v[3:1]};
         2'b01:   return {v[2:0], f};
         2'b10:   return {v[0], v[3:1]};
         default: return {v[2:0], v[3]};
      endcase
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic b, input logic d, input logic [3:0] v);
      obs_t e;
      e.busy = b; e.done = d; e.q = v;
      sb.push_back(e);
   endtask

   // Monitor: every negedge with pending expectations compares {busy,done,q}.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         obs_t e;
         e = sb.pop_front();
         check("cycle", {busy, done, q}, {e.busy, e.done, e.q});
      end
   end

   task automatic run_cmd(input vec_t v);
      logic [3:0] m;
      int n;
      n = int'(v.count) + 2 + ((v.hold_after >= 1 && v.hold_after < int'(v.count)) ? v.hold_len : 0);
      @(posedge clk); #2;
      start = 1'b1; data = v.data; op = v.op; fill = v.fill; count = v.count; hold = 1'b0;
      push(1'b0, 1'b0, prev_q);
      push(1'b1, 1'b0, prev_q);
      m = v.data;
      if (v.count == 4'd0) begin
         push(1'b0, 1'b1, m);
      end else begin
         push(1'b1, 1'b0, m);
         for (int k = 1; k <= int'(v.count); k++) begin
            m = model_step(m, v.op, v.fill);
            if (k == int'(v.count)) push(1'b0, 1'b1, m);
            else push(1'b1, 1'b0, m);
            if (k == v.hold_after) begin
               for (int j = 0; j < v.hold_len; j++) push(1'b1, 1'b0, m);
            end
         end
      end
      push(1'b0, 1'b0, m);
      for (int c = 0; c <= n; c++) begin
         @(posedge clk); #2;
         start = (c + 1 == v.start_at) && (c < n);
         data  = 4'($urandom); op = 2'($urandom); fill = 1'($urandom); count = 4'($urandom);
         hold  = (v.hold_after >= 1) && (c + 1 >= 2 + v.hold_after) && (c + 1 <= 1 + v.hold_after + v.hold_len);
      end
      start = 1'b0; hold = 1'b0;
      @(negedge clk); #1;
      check("final_q", {2'b00, q}, {2'b00, v.exp_final});
      check("sb_drained", 6'(sb.size()), 6'd0);
      prev_q = m;
   endtask

   initial begin
      vecs[0] = '{4'b0110, 2'b01, 1'b1, 4'd2, -1, 0, -1, 4'b1011};
      vecs[1] = '{4'b1001, 2'b10, 1'b0, 4'd3, -1, 0, -1, 4'b0011};
      vecs[2] = '{4'b1010, 2'b00, 1'b0, 4'd0, -1, 0, -1, 4'b1010};
      vecs[3] = '{4'b1111, 2'b00, 1'b0, 4'd4,  1, 2, -1, 4'b0000};
      vecs[4] = '{4'b0101, 2'b11, 1'b0, 4'd3, -1, 0,  3, 4'b1010};
      vecs[5] = '{4'b1000, 2'b11, 1'b1, 4'd15, -1, 0, -1, 4'b0100};
      vecs[6] = '{4'b1111, 2'b01, 1'b0, 4'd5,  2, 1, -1, 4'b0000};
      vecs[7] = '{4'b0011, 2'b10, 1'b1, 4'd1, -1, 0,  3, 4'b1001};

      rst_n = 1'b0; start = 1'b0; data = 4'd0; op = 2'd0; fill = 1'b0; count = 4'd0; hold = 1'b0;
      prev_q = 4'd0;
      #12;
      check("reset_state", {busy, done, q}, 6'b000000);
      @(posedge clk); #2;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

      // Reset aborts a running command immediately and suppresses Done.
      @(posedge clk); #2;
      start = 1'b1; data = 4'b1100; op = 2'b00; fill = 1'b1; count = 4'd6;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("pre_abort_busy", {5'b00000, busy}, 6'b000001);
      rst_n = 1'b0;
      #1;
      check("abort_async", {busy, done, q}, 6'b000000);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_no_done", {busy, done, q}, 6'b000000);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      prev_q = 4'd0;
      run_cmd(vecs[0]);
      run_cmd(vecs[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
